// File: rtl/ls_usb_recv.sv
// Low-speed USB receiver: line sync, bit recovery, NRZI decode, de-stuffing, byte and EOP framing.
// Defining LS_USB_RECV_CRC16_EN adds a CRC16 residual check of everything after the PID.
module ls_usb_recv #(
  parameter int CLK_PER_BIT  = 8,
  parameter int SAMPLE_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dp,
  input  logic       dm,
  input  logic       rx_ena,
  output logic [7:0] rbyte,
  output logic       rbyte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic       crc_ok,
  output logic       receiving
);

  localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_e;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, WAIT_J} state_e;

  state_e        state, state_d;
  logic [1:0]    dp_sync, dm_sync;
  line_e         line, line_q, prev_line, prev_val;
  logic [PW-1:0] phase;
  logic          sample, dec_bit;
  logic [2:0]    cnt, ones, bit_cnt;
  logic [7:0]    shreg;
  logic          start, term, term_err, shift_en, drop;
  logic          prev_load, cnt_inc, cnt_clr, phase_clr, crc_good;

  assign line    = line_e'({dp_sync[1], dm_sync[1]});
  assign sample  = (phase == PW'(SAMPLE_PHASE));
  assign dec_bit = (line == prev_line);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    term      = 1'b0;
    term_err  = 1'b0;
    shift_en  = 1'b0;
    drop      = 1'b0;
    prev_load = 1'b0;
    prev_val  = prev_line;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    phase_clr = 1'b0;
    unique case (state)
      IDLE: begin
        prev_load = 1'b1;
        prev_val  = LS_J;
        if (rx_ena && line == LS_K) begin
          state_d   = SYNC;
          phase_clr = 1'b1;
        end
      end
      SYNC: begin
        if (!rx_ena) begin
          state_d = IDLE;
        end else if (sample) begin
          if (line == LS_SE0) begin
            state_d = IDLE;
          end else if (line == LS_K && prev_line == LS_K) begin
            start     = 1'b1;
            state_d   = DATA;
            prev_load = 1'b1;
            prev_val  = LS_K;
          end else if (cnt == 3'd7) begin
            state_d = IDLE;
          end else begin
            cnt_inc   = 1'b1;
            prev_load = 1'b1;
            prev_val  = line;
          end
        end
      end
      DATA: begin
        if (!rx_ena) begin
          term     = 1'b1;
          term_err = 1'b1;
          state_d  = IDLE;
        end else if (sample) begin
          if (line == LS_SE0) begin
            state_d = EOP;
          end else if (line == LS_SE1) begin
            term     = 1'b1;
            term_err = 1'b1;
            state_d  = WAIT_J;
          end else begin
            prev_load = 1'b1;
            prev_val  = line;
            // Seventh bit after six ones is a stuff bit: must be 0.
            if (ones == 3'd6) begin
              if (dec_bit) begin
                term     = 1'b1;
                term_err = 1'b1;
                state_d  = WAIT_J;
              end else begin
                drop = 1'b1;
              end
            end else begin
              shift_en = 1'b1;
            end
          end
        end
      end
      EOP: begin
        if (!rx_ena) begin
          term     = 1'b1;
          term_err = 1'b1;
          state_d  = IDLE;
        end else if (sample) begin
          if (line == LS_J) begin
            term     = 1'b1;
            term_err = (bit_cnt != 3'd0);
            state_d  = IDLE;
          end else if (line != LS_SE0) begin
            term     = 1'b1;
            term_err = 1'b1;
            state_d  = WAIT_J;
          end
        end
      end
      WAIT_J: begin
        if (sample) begin
          if (line != LS_J)       cnt_clr = 1'b1;
          else if (cnt == 3'd1)   state_d = IDLE;
          else                    cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state) cnt_clr = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_sync     <= 2'b00;
      dm_sync     <= 2'b00;
      line_q      <= LS_SE0;
      phase       <= '0;
      prev_line   <= LS_SE0;
      cnt         <= 3'd0;
      ones        <= 3'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rbyte       <= 8'h00;
      rbyte_valid <= 1'b0;
      pkt_start   <= 1'b0;
      pkt_end     <= 1'b0;
      pkt_err     <= 1'b0;
      crc_ok      <= 1'b0;
      receiving   <= 1'b0;
    end else begin
      dp_sync <= {dp_sync[0], dp};
      dm_sync <= {dm_sync[0], dm};
      line_q  <= line;
      if (phase_clr || line != line_q || phase == PW'(CLK_PER_BIT - 1)) phase <= '0;
      else                                                              phase <= phase + 1'b1;

      if (prev_load) prev_line <= prev_val;
      if (cnt_clr)      cnt <= 3'd0;
      else if (cnt_inc) cnt <= cnt + 3'd1;

      pkt_start   <= start;
      pkt_end     <= term;
      pkt_err     <= term & term_err;
      crc_ok      <= term & crc_good;
      rbyte_valid <= 1'b0;
      if (start)     receiving <= 1'b1;
      else if (term) receiving <= 1'b0;

      if (start) begin
        ones    <= 3'd0;
        bit_cnt <= 3'd0;
      end else if (drop) begin
        ones <= 3'd0;
      end else if (shift_en) begin
        shreg   <= {dec_bit, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        ones    <= dec_bit ? ones + 3'd1 : 3'd0;
        if (bit_cnt == 3'd7) begin
          rbyte       <= {dec_bit, shreg[7:1]};
          rbyte_valid <= 1'b1;
        end
      end
    end
  end

`ifdef LS_USB_RECV_CRC16_EN
  logic [15:0] crc;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc      <= 16'hFFFF;
      byte_cnt <= 2'd0;
    end else if (start) begin
      crc      <= 16'hFFFF;
      byte_cnt <= 2'd0;
    end else if (shift_en) begin
      // PID bits are excluded; byte_cnt saturates at 3, which is all the check needs.
      if (byte_cnt != 2'd0)
        crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ dec_bit) ? 16'h8005 : 16'h0000);
      if (bit_cnt == 3'd7 && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign crc_good = (crc == 16'h800D) && (byte_cnt == 2'd3);
`else
  assign crc_good = 1'b0;
`endif

endmodule

// File: doc/ls_usb_recv.md
Name: ls_usb_recv

Overview:
Low-speed (1.5 Mbit/s) USB packet receiver for the usbhost block, running on the 12 MHz clock. It is the receive-side counterpart of the low-speed sender. It synchronizes dp/dm, recovers bit timing, detects SYNC, NRZI-decodes and de-stuffs the stream, and delivers bytes LSB-first. It also detects EOP and flags stuff, framing and line errors. Its output feeds the host packet engine (handshake/data PID decode).

Parameters:
CLK_PER_BIT, 8, clocks per LS bit (12 MHz / 1.5 MHz)
SAMPLE_PHASE, 4, phase-counter value at which the line is sampled (mid-bit)

Ports:
clk  input  1  12 MHz clock
reset  input  1  asynchronous active-high reset
dp  input  1  raw USB D+ (asynchronous to clk)
dm  input  1  raw USB D- (asynchronous to clk)
rx_ena  input  1  receive enable; held low while own transmitter drives the bus
rbyte  output  8  received byte, valid with rbyte_valid
rbyte_valid  output  1  one-clk strobe: rbyte holds a new byte
pkt_start  output  1  one-clk strobe: SYNC completed
pkt_end  output  1  one-clk strobe: packet terminated (normal or error)
pkt_err  output  1  qualifies pkt_end: packet terminated abnormally
crc_ok  output  1  qualifies pkt_end (see Optional Feature)
receiving  output  1  high from pkt_start until pkt_end

Behaviour:
- Reset: all outputs 0. State IDLE; synchronizers, phase counter, shift register and counters all cleared.
- Input conditioning: dp and dm each pass through a 2-FF synchronizer.
- Line states (LS polarity): J = dp0/dm1, K = dp1/dm0, SE0 = 00, SE1 = 11.
- Bit timing: phase counter 0..CLK_PER_BIT-1 wraps. It is forced to 0 on any change of synchronized line state. Sample strobe fires when counter == SAMPLE_PHASE.
- NRZI decode: decoded bit = 1 if the sampled state equals the previous sampled state, 0 otherwise.
- FSM states: IDLE, SYNC, DATA, EOP, WAIT_J.
- IDLE: when rx_ena=1 and synchronized state is K, go to SYNC with phase reset.
- SYNC: on each sample, once two consecutive samples are K, pulse pkt_start, set receiving, go to DATA. Previous-state is K; ones count and bit count are 0.
- SYNC abort: if SE0 is sampled, or 8 samples pass without KK, return to IDLE silently.
- DATA sampling:
  - SE0 sampled: go to EOP.
  - SE1 sampled: error termination.
  - Otherwise, decode the bit.
- DATA de-stuffing: if the ones count is already 6, this bit is a stuff bit.
  - Stuff bit = 0: drop it and clear the ones count.
  - Stuff bit = 1: stuff error, error termination.
- DATA shifting: a non-stuff bit shifts into the byte register (right shift, new bit at [7]) and bit_cnt increments modulo 8. The ones count increments on 1 and clears on 0.
- Byte delivery: when bit_cnt wraps 7→0, rbyte is loaded and rbyte_valid pulses on the clock after the sample strobe.
- EOP: sampled SE0 keeps waiting. Sampled J produces a normal termination, but pkt_err=1 if bit_cnt != 0 (partial byte, which is discarded). Sampled K produces error termination.
- Termination: pkt_end pulses for one clk with pkt_err/crc_ok valid in the same clk, and receiving clears.
- After termination: a normal end goes to IDLE. An error end goes to WAIT_J, which returns to IDLE after 2 consecutive J samples.
- rx_ena falling in SYNC: return to IDLE silently.
- rx_ena falling in DATA or EOP: immediate error termination, then IDLE.
- Strobe simultaneity: rbyte_valid and pkt_end never fire in the same clk.
- Async reset mid-packet: abandon immediately; no pkt_end.

Optional Feature:
LS_USB_RECV_CRC16_EN
- Defined: CRC16 (poly x16+x15+x2+1, LSB-first, init 16'hFFFF) runs over every de-stuffed bit after the first byte (PID) of the packet. crc_ok = 1 at pkt_end iff the register equals residual 16'h800D and at least 3 bytes were received.
- Undefined: crc_ok is tied to 0 and no CRC logic is built.

Test Plan:
1. SYNC + byte 0x5A + 2-bit SE0 + J, rx_ena=1 -> pkt_start; one rbyte_valid with rbyte=0x5A; pkt_end with pkt_err=0; receiving low afterwards.
2. SYNC + 0xFF + 0x3F + EOP, with a stuffed 0 inserted after each run of six 1s -> rbyte 0xFF then 0x3F, stuff bits removed, pkt_err=0.
3. SYNC followed by seven consecutive decoded 1s -> pkt_end with pkt_err=1, no rbyte_valid, then return to IDLE after J.
4. SYNC + 12 data bits (0xA5 then 4 bits) + EOP -> one rbyte_valid (0xA5); pkt_end with pkt_err=1.
5. Valid packet driven with rx_ena=0 -> no pkt_start, rbyte_valid or pkt_end. Dropping rx_ena mid-byte -> pkt_end with pkt_err=1.
6. (CRC16_EN) Zero-length DATA0 (0xC3, 0x00, 0x00) -> crc_ok=1 at pkt_end. Same packet with bit 0 of the second byte flipped -> crc_ok=0.
